mux2_rr_arbiter: RTL and testbench



---
 rtl/mux2_rr_arbiter_pkg.sv | 11 +
 rtl/mux2_rr_arbiter.sv | 62 ++++++
 tb/tb_mux2_rr_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mux2_rr_arbiter_pkg.sv
// mux2_rr_arbiter_pkg: shared state encoding and burst counter sizing for the round-robin 2:1 mux arbiter
package mux2_rr_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;
  function automatic int burst_cnt_w(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction
endpackage

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin arbiter with bounded bursts driving a registered 2:1 data mux
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              sel,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid
);
  localparam int CW = burst_cnt_w(MAX_BURST);
  localparam logic [CW-1:0] BMAX = CW'(MAX_BURST - 1);
  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  assign gnt0       = (state_q == G0);
  assign gnt1       = (state_q == G1);
  assign sel        = gnt1;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  // Next grant: last_q=1 hands ties to requester 0; a held grant yields once its burst is spent
  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = (req0 && (!req1 || last_q)) ? G0 : req1 ? G1 : IDLE;
      G0:      state_d = !req0 ? (req1 ? G1 : IDLE) : (req1 && cnt_q == BMAX) ? G1 : G0;
      G1:      state_d = !req1 ? (req0 ? G0 : IDLE) : (req0 && cnt_q == BMAX) ? G0 : G1;
      default: state_d = IDLE;
    endcase
    cnt_d        = (state_d != state_q || state_q == IDLE) ? '0 : (cnt_q == BMAX) ? cnt_q : cnt_q + 1'b1;
    last_d       = (state_d != state_q && state_d != IDLE) ? (state_d == G1) : last_q;
    dout_valid_d = gnt0 | gnt1;
    dout_d       = (gnt0 | gnt1) ? (sel ? din1 : din0) : dout_q;
  end
  // State, burst bookkeeping and registered data path
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: directed self-checking bench for the round-robin 2:1 mux arbiter
module tb_mux2_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] din0 = 8'h11;
  logic [7:0] din1 = 8'hA5;
  logic       gnt0, gnt1, sel, dout_valid;
  logic [7:0] dout;
  int         errors = 0;
  int         checks = 0;
  mux2_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .dout(dout), .dout_valid(dout_valid)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    // reset held with both requesting
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    tick();
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    rst = 1'b0;
    // contention: G0 x4, G1 x4, G0 x4
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("cont_gnt0_%0d", k), 32'(gnt0), 32'((k <= 4) || (k >= 9)));
      chk($sformatf("cont_gnt1_%0d", k), 32'(gnt1), 32'((k >= 5) && (k <= 8)));
      chk($sformatf("cont_sel_%0d", k), 32'(sel), 32'((k >= 5) && (k <= 8)));
      if (k == 2) chk("cont_dout_g0", 32'(dout), 32'h11);
      if (k == 6) chk("cont_dout_g1", 32'(dout), 32'hA5);
      if (k >= 2) chk($sformatf("cont_valid_%0d", k), 32'(dout_valid), 1);
    end
    // release both: IDLE, valid trails by one cycle, dout holds
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    chk("idle_gnt", 32'({gnt0, gnt1}), 0);
    chk("idle_valid_tail", 32'(dout_valid), 1);
    tick();
    chk("idle_valid", 32'(dout_valid), 0);
    chk("idle_dout_hold", 32'(dout), 32'h11);
    // single requester 1
    req1 = 1'b1;
    tick();
    chk("single_gnt1", 32'(gnt1), 1);
    chk("single_sel", 32'(sel), 1);
    chk("single_valid0", 32'(dout_valid), 0);
    tick();
    chk("single_dout", 32'(dout), 32'hA5);
    chk("single_valid", 32'(dout_valid), 1);
    din1 = 8'h3C;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("single_hold_%0d", k), 32'({gnt0, gnt1}), 32'b01);
    end
    chk("single_dout_new", 32'(dout), 32'h3C);
    // early release: G0 for 2 cycles then req0 drops while req1 waits
    req1 = 1'b0;
    tick();
    chk("er_idle", 32'({gnt0, gnt1}), 0);
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    chk("er_g0_1", 32'(gnt0), 1);
    tick();
    chk("er_g0_2", 32'(gnt0), 1);
    req0 = 1'b0;
    tick();
    chk("er_switch", 32'({gnt0, gnt1}), 32'b01);
    req1 = 1'b0;
    tick();
    chk("er_idle2", 32'({gnt0, gnt1}), 0);
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    chk("er_last1_tie", 32'({gnt0, gnt1}), 32'b10);
    // tie after idle with requester 0 served last
    req1 = 1'b0;
    tick();
    chk("tie_g0", 32'(gnt0), 1);
    req0 = 1'b0;
    tick();
    chk("tie_idle", 32'({gnt0, gnt1}), 0);
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    chk("tie_g1_first", 32'({gnt0, gnt1}), 32'b01);
    // reset in the 3rd cycle of G1
    tick();
    tick();
    chk("mid_g1_3", 32'(gnt1), 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_gnt1", 32'(gnt1), 0);
    chk("mid_rst_valid", 32'(dout_valid), 0);
    chk("mid_rst_dout", 32'(dout), 0);
    rst = 1'b0;
    tick();
    chk("mid_after_g0", 32'({gnt0, gnt1}), 32'b10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
